approx_ks_adder_pipe: RTL and testbench

Parametrised, pipelined successor to the 8-bit approximate Kogge-Stone adder. It accepts a WIDTH-bit operand pair per transaction and produces a (WIDTH+1)-bit sum. A per-transaction mode bit selects the exact carry or the windowed (approximate) carry. It also computes the exact sum internally, flags any mismatch and keeps a saturating mismatch counter. It sits in the accuracy-evaluation datapath, behind valid/ready streams.

---
 rtl/approx_ks_adder_pipe.sv | 169 ++++++++++++++++
 tb/tb_approx_ks_adder_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_ks_adder_pipe.sv
// Three-stage pipelined Kogge-Stone adder with a per-transaction exact/windowed carry select,
// exact-sum comparison and a saturating mismatch counter, behind valid/ready streams.
module approx_ks_adder_pipe #(
   parameter int WIDTH = 32'sd16,
   parameter int SPAN  = 32'sd4,
   parameter int CNT_W = 32'sd16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_approx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic [WIDTH:0]   out_exact,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             cnt_clr
);

   localparam int LV  = $clog2(WIDTH);
   localparam int LS  = $clog2(SPAN);
   localparam int L1  = (LV + 32'sd1) / 32'sd2;
   localparam int LA1 = (L1 < LS) ? L1 : LS;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Group generate after applying prefix levels lo..hi-1 (level k spans distance 2**k).
   function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g_in,
                                             input logic [WIDTH-1:0] p_in,
                                             input int lo, input int hi);
      logic [WIDTH-1:0] g_v, p_v, g_n, p_n;
      int d;
      g_v = g_in;
      p_v = p_in;
      for (int k = lo; k < hi; k++) begin
         d = 32'sd1 << k;
         for (int i = 32'sd0; i < WIDTH; i++) begin
            if (i >= d) begin
               g_n[i] = g_v[i] | (p_v[i] & g_v[i - d]);
               p_n[i] = p_v[i] & p_v[i - d];
            end else begin
               g_n[i] = g_v[i];
               p_n[i] = p_v[i];
            end
         end
         g_v = g_n;
         p_v = p_n;
      end
      return g_v;
   endfunction

   // Group propagate after applying prefix levels lo..hi-1.
   function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p_in,
                                             input int lo, input int hi);
      logic [WIDTH-1:0] p_v, p_n;
      int d;
      p_v = p_in;
      for (int k = lo; k < hi; k++) begin
         d = 32'sd1 << k;
         for (int i = 32'sd0; i < WIDTH; i++) begin
            if (i >= d) begin
               p_n[i] = p_v[i] & p_v[i - d];
            end else begin
               p_n[i] = p_v[i];
            end
         end
         p_v = p_n;
      end
      return p_v;
   endfunction

   logic             adv_s;
   logic             v1_r, mode1_r;
   logic [WIDTH-1:0] p1_r, g1_r;
   logic             v2_r, mode2_r;
   logic [WIDTH-1:0] p2_r, ge2_r, pe2_r, ga2_r, pa2_r;
   logic [WIDTH-1:0] g_e_s, g_a_s;
   logic [WIDTH:0]   c_e_s, c_a_s, sum_e_s, sum_a_s, sum_sel_s;

   assign adv_s    = !out_valid || out_ready;
   assign in_ready = adv_s;

   // Stage 1: bitwise propagate/generate and mode capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r    <= 1'b0;
         mode1_r <= 1'b0;
         p1_r    <= '0;
         g1_r    <= '0;
      end else if (adv_s) begin
         v1_r <= in_valid;
         if (in_valid) begin
            mode1_r <= in_approx;
            p1_r    <= in_a ^ in_b;
            g1_r    <= in_a & in_b;
         end
      end
   end

   // Stage 2: first half of both prefix trees; the windowed tree never goes past LS levels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_r    <= 1'b0;
         mode2_r <= 1'b0;
         p2_r    <= '0;
         ge2_r   <= '0;
         pe2_r   <= '0;
         ga2_r   <= '0;
         pa2_r   <= '0;
      end else if (adv_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            mode2_r <= mode1_r;
            p2_r    <= p1_r;
            ge2_r   <= ks_g(g1_r, p1_r, 32'sd0, L1);
            pe2_r   <= ks_p(p1_r, 32'sd0, L1);
            ga2_r   <= ks_g(g1_r, p1_r, 32'sd0, LA1);
            pa2_r   <= ks_p(p1_r, 32'sd0, LA1);
         end
      end
   end

   // Remaining prefix levels, carry vectors and both sums.
   always_comb begin
      g_e_s   = ks_g(ge2_r, pe2_r, L1, LV);
      g_a_s   = ks_g(ga2_r, pa2_r, LA1, LS);
      c_e_s   = {g_e_s, 1'b0};
      c_a_s   = {g_a_s, 1'b0};
      sum_e_s = {c_e_s[WIDTH], p2_r ^ c_e_s[WIDTH-1:0]};
      sum_a_s = {c_a_s[WIDTH], p2_r ^ c_a_s[WIDTH-1:0]};
      if (mode2_r) begin
         sum_sel_s = sum_a_s;
      end else begin
         sum_sel_s = sum_e_s;
      end
   end

   // Stage 3: registered result and mismatch flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_exact <= '0;
         out_err   <= 1'b0;
      end else if (adv_s) begin
         out_valid <= v2_r;
         if (v2_r) begin
            out_sum   <= sum_sel_s;
            out_exact <= sum_e_s;
            out_err   <= (sum_sel_s != sum_e_s);
         end
      end
   end

   // Saturating mismatch counter; clear wins over a coincident increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (cnt_clr) begin
         err_cnt <= '0;
      end else if (out_valid && out_ready && out_err && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + CNT_W'(1'b1);
      end
   end

endmodule

// File: tb/tb_approx_ks_adder_pipe.sv
// Directed bench for approx_ks_adder_pipe: default instance plus a CNT_W=2 instance sharing
// the same stimulus, used for the counter saturation scenario.
module tb_approx_ks_adder_pipe;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_approx, out_ready, cnt_clr;
   logic [15:0] in_a, in_b;
   logic        in_ready, out_valid, out_err;
   logic [16:0] out_sum, out_exact;
   logic [15:0] err_cnt;
   logic        in_ready2, out_valid2, out_err2;
   logic [16:0] out_sum2, out_exact2;
   logic [1:0]  err_cnt2;

   int n_vec = 0;
   int n_err = 0;

   approx_ks_adder_pipe #(.WIDTH(16), .SPAN(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_exact(out_exact),
      .out_err(out_err), .err_cnt(err_cnt), .cnt_clr(cnt_clr));

   approx_ks_adder_pipe #(.WIDTH(16), .SPAN(4), .CNT_W(2)) dut_c2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid2),
      .out_ready(out_ready), .out_sum(out_sum2), .out_exact(out_exact2),
      .out_err(out_err2), .err_cnt(err_cnt2), .cnt_clr(cnt_clr));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; in_approx = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      in_a = 16'h0000; in_b = 16'h0000;
      #2;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      n_vec++; if (err_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_err_cnt: got %0h want 0", err_cnt); end
      n_vec++; if (out_sum !== 17'h00000) begin n_err++; $display("FAIL reset_out_sum: got %0h want 0", out_sum); end
      n_vec++; if (out_exact !== 17'h00000) begin n_err++; $display("FAIL reset_out_exact: got %0h want 0", out_exact); end
      n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err: got %0b want 0", out_err); end
      tick; tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_exact_carry;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_approx = 1'b0;
      tick;
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL exact_lat_n: got %0b want 0", out_valid); end
      tick;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL exact_lat_n1: got %0b want 0", out_valid); end
      tick;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL exact_lat_n2: got %0b want 1", out_valid); end
      n_vec++; if (out_sum !== 17'h10000) begin n_err++; $display("FAIL exact_sum: got %0h want 10000", out_sum); end
      n_vec++; if (out_exact !== 17'h10000) begin n_err++; $display("FAIL exact_exact: got %0h want 10000", out_exact); end
      n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL exact_err: got %0b want 0", out_err); end
      tick;
      n_vec++; if (err_cnt !== 16'h0000) begin n_err++; $display("FAIL exact_cnt: got %0h want 0", err_cnt); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL exact_drain: got %0b want 0", out_valid); end
   endtask

   task automatic test_approx_carry;
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_approx = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL approx_valid: got %0b want 1", out_valid); end
      n_vec++; if (out_sum !== 17'h0FFE0) begin n_err++; $display("FAIL approx_sum: got %0h want 0ffe0", out_sum); end
      n_vec++; if (out_exact !== 17'h10000) begin n_err++; $display("FAIL approx_exact: got %0h want 10000", out_exact); end
      n_vec++; if (out_err !== 1'b1) begin n_err++; $display("FAIL approx_err: got %0b want 1", out_err); end
      n_vec++; if (err_cnt !== 16'h0000) begin n_err++; $display("FAIL approx_cnt_pre: got %0h want 0", err_cnt); end
      tick;
      n_vec++; if (err_cnt !== 16'h0001) begin n_err++; $display("FAIL approx_cnt: got %0h want 1", err_cnt); end
      n_vec++; if (err_cnt2 !== 2'd1) begin n_err++; $display("FAIL approx_cnt2: got %0h want 1", err_cnt2); end
   endtask

   task automatic test_no_generate;
      in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0101; in_approx = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick;
      n_vec++; if (out_sum !== 17'h01335) begin n_err++; $display("FAIL nogen_sum: got %0h want 01335", out_sum); end
      n_vec++; if (out_exact !== 17'h01335) begin n_err++; $display("FAIL nogen_exact: got %0h want 01335", out_exact); end
      n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL nogen_err: got %0b want 0", out_err); end
      tick;
      n_vec++; if (err_cnt !== 16'h0001) begin n_err++; $display("FAIL nogen_cnt: got %0h want 1", err_cnt); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] va [5];
      logic [15:0] vb [5];
      logic [16:0] ve [5];
      int sent, got, stalls;
      va = '{16'h0001, 16'h8000, 16'h00FF, 16'h1111, 16'hFFFF};
      vb = '{16'h0002, 16'h8000, 16'h0001, 16'h2222, 16'hFFFF};
      ve = '{17'h00003, 17'h10000, 17'h00100, 17'h03333, 17'h1FFFE};
      sent = 0; got = 0; stalls = 0; in_approx = 1'b0;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         out_ready = !(cyc >= 3 && cyc < 7);
         #1;
         if (out_valid && out_ready) begin
            n_vec++; if (out_sum !== ve[got]) begin n_err++; $display("FAIL b2b_order[%0d]: got %0h want %0h", got, out_sum, ve[got]); end
            got++;
         end else if (out_valid) begin
            stalls++;
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready c%0d: got %0b want 0", cyc, in_ready); end
            n_vec++; if (out_sum !== ve[got]) begin n_err++; $display("FAIL b2b_hold c%0d: got %0h want %0h", cyc, out_sum, ve[got]); end
         end
         if (in_ready && sent < 5) begin
            in_valid = 1'b1; in_a = va[sent]; in_b = vb[sent]; sent++;
         end else begin
            in_valid = 1'b0;
         end
         tick;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_vec++; if (got !== 5) begin n_err++; $display("FAIL b2b_count: got %0d want 5", got); end
      n_vec++; if (stalls !== 4) begin n_err++; $display("FAIL b2b_stalls: got %0d want 4", stalls); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_no_dup: got %0b want 0", out_valid); end
      n_vec++; if (err_cnt !== 16'h0001) begin n_err++; $display("FAIL b2b_cnt: got %0h want 1", err_cnt); end
   endtask

   task automatic test_saturate;
      logic [1:0] e2 [5];
      e2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      out_ready = 1'b1;
      cnt_clr = 1'b1;
      tick;
      cnt_clr = 1'b0;
      n_vec++; if (err_cnt2 !== 2'd0) begin n_err++; $display("FAIL sat_clr2: got %0h want 0", err_cnt2); end
      n_vec++; if (err_cnt !== 16'h0000) begin n_err++; $display("FAIL sat_clr: got %0h want 0", err_cnt); end
      for (int t = 0; t < 5; t++) begin
         in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_approx = 1'b1;
         tick;
         in_valid = 1'b0;
         tick; tick;
         n_vec++; if (out_err2 !== 1'b1) begin n_err++; $display("FAIL sat_err[%0d]: got %0b want 1", t, out_err2); end
         tick;
         n_vec++; if (err_cnt2 !== e2[t]) begin n_err++; $display("FAIL sat_cnt2[%0d]: got %0d want %0d", t, err_cnt2, e2[t]); end
         n_vec++; if (err_cnt !== 16'(t + 1)) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", t, err_cnt, t + 1); end
      end
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_approx = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick;
      cnt_clr = 1'b1;
      tick;
      cnt_clr = 1'b0;
      n_vec++; if (err_cnt2 !== 2'd0) begin n_err++; $display("FAIL clr_override2: got %0d want 0", err_cnt2); end
      n_vec++; if (err_cnt !== 16'h0000) begin n_err++; $display("FAIL clr_override: got %0d want 0", err_cnt); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_handshake: got %0b want 0", out_valid); end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_approx = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick; tick;
      n_vec++; if (err_cnt !== 16'h0001) begin n_err++; $display("FAIL rmid_pre_cnt: got %0d want 1", err_cnt); end
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_approx = 1'b1;
         tick;
      end
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid: got %0b want 1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %0b want 0", out_valid); end
      n_vec++; if (err_cnt !== 16'h0000) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", err_cnt); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %0b want 1", in_ready); end
      n_vec++; if (out_sum !== 17'h00000) begin n_err++; $display("FAIL rmid_sum: got %0h want 0", out_sum); end
      n_vec++; if (out_err !== 1'b0) begin n_err++; $display("FAIL rmid_err: got %0b want 0", out_err); end
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale[%0d]: got %0b want 0", i, out_valid); end
      end
      in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0004; in_approx = 1'b0;
      tick;
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_lat_n: got %0b want 0", out_valid); end
      tick;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_lat_n1: got %0b want 0", out_valid); end
      tick;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_lat_n2: got %0b want 1", out_valid); end
      n_vec++; if (out_sum !== 17'h00007) begin n_err++; $display("FAIL rmid_sum_new: got %0h want 7", out_sum); end
      tick;
   endtask

   initial begin
      test_reset;
      test_exact_carry;
      test_approx_carry;
      test_no_generate;
      test_back_to_back;
      test_saturate;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
